sm_accum_seq: RTL
=================

Name: sm_accum_seq

Overview:
- Sequential accumulator for 23-bit sign-magnitude words: bit 22 is the sign (1 = negative) and bits 21:0 are the magnitude.
- Consumes a valid/ready stream of terms, e.g. weight*input products of a neuron, and sums a programmable number of terms (1-16) into one result.
- Presents that result on a valid/ready output port.
- Sits between the product stage and the activation stage of the simple neuron, supplying the multi-term sum that a single-step adder cannot.

Parameters:
- W, 23, total word width including the sign bit.
- MAX_TERMS, 16, maximum terms per group; the term-count field is 4 bits, and value 0 encodes 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: discard the partial group and return to IDLE.
- cfg_terms  input  4  terms per group, sampled on the first accepted term; 0 means 16.
- in_valid  input  1  a term is present.
- in_ready  output  1  the block can accept a term.
- in_data  input  W  sign-magnitude term.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  sign-magnitude sum.
- out_sat  output  1  magnitude clamped at least once during the group.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; accumulator=+0; term counter=0; sat flag=0.
  - out_valid=0, out_data=0, out_sat=0; in_ready=0 while rst_n is low.
- States:
  - IDLE: in_ready=1. On accept, latch N (cfg_terms, with 0 giving 16). The accumulator loads the term, with -0 normalised to +0. Counter=1. Go to ACC, or straight to HOLD if N=1.
  - ACC: in_ready=1. On each accept, accumulator = accumulator (+) term and counter increments. When the accepted term is the Nth, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, and out_data/out_sat are held stable. When out_ready=1, go to IDLE, with out_valid low the next cycle.
- Latency: out_valid rises on the cycle after the Nth term is accepted, and the result includes that Nth term.
- Back-to-back groups: in HOLD, in_ready stays 0 even on the handshake cycle, so at least one IDLE cycle precedes the next group's first term.
- Sign-magnitude add (+) on 22-bit magnitudes, A=accumulator and B=term:
  - Same sign: compute the 23-bit sum. If bit 22 is set, clamp the magnitude to 22'h3FFFFF, keep the sign, and set sat.
  - Different signs, |B|>|A|: magnitude |B|-|A|, sign of B.
  - Different signs, |A|>|B|: magnitude |A|-|B|, sign of A.
  - Different signs, equal magnitudes: result is +0 (sign forced 0).
  - Any zero result is emitted as +0; -0 inputs are treated as +0.
- Saturation:
  - Accumulation continues from the clamped value.
  - sat is sticky for the group and cleared on the first accept of the next group.
- in_valid while in HOLD: the term is not accepted and must be held by the source.
- clear:
  - clear=1 forces IDLE, zeroes the accumulator/counter/sat, and drops out_valid next cycle.
  - clear has priority over a simultaneous accept or handshake, and the term presented that cycle is dropped.
- cfg_terms changes mid-group are ignored; the latched N governs the whole group.
- Reset asserted mid-group: the partial sum is lost with no output; after release the block is in IDLE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Basic sum: cfg_terms=3; terms +5 (0x000005), +7, -3 (0x400003) accepted on consecutive cycles -> out_valid on the cycle after the 3rd accept, out_data=0x000009, out_sat=0.
- Sign flip and zero: cfg_terms=2; -10 then +10 -> out_data=0x000000 (not 0x400000). Then cfg_terms=2; -10 then +4 -> out_data=0x400006.
- Saturation: cfg_terms=3; +0x3FFFFF, +0x000002, -0x000010 -> out_data=0x3FFFEF, out_sat=1. The next group of 1 term, +1, gives out_sat=0.
- Backpressure:
  - cfg_terms=1, +1 accepted, then out_ready held low for 5 cycles -> out_valid=1 and out_data stable; in_ready=0 throughout.
  - Assert out_ready -> handshake, out_valid=0 next cycle, in_ready=1.
- cfg_terms=0: 16 terms of +0x000100 -> out_data=0x001000 after the 16th accept. out_valid stays low after the 15th.
- Abort and reset:
  - clear pulsed after 2 of 4 terms -> no output, and the next group starts from +0.
  - rst_n pulsed low asynchronously mid-group -> all outputs 0 immediately; after release, a fresh 1-term group of +2 gives 0x000002.

Source files
------------

// File: rtl/sm_accum_seq.sv
// ---------------------------------------------------------------------------
// sm_accum_seq
//
// Sequential accumulator for sign-magnitude words. Bit W-1 is the sign
// (1 = negative) and bits W-2:0 are the magnitude. A group of N terms
// (N = cfg_terms, where 0 encodes MAX_TERMS) is summed one term per accepted
// handshake. The result is then presented on a valid/ready output port until
// downstream takes it. Any magnitude overflow clamps to full scale and sets a
// flag that stays set for the rest of the group.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current group (returns to IDLE)
//   cfg_terms  terms per group, sampled on the first accepted term (0 = 16)
//   in_valid   a term is present on in_data
//   in_ready   the block can accept a term
//   in_data    sign-magnitude term
//   out_valid  out_data / out_sat hold a finished group result
//   out_ready  downstream accepts the result
//   out_data   sign-magnitude sum
//   out_sat    magnitude was clamped at least once during the group
// ---------------------------------------------------------------------------
module sm_accum_seq #(
    parameter int W         = 23,
    parameter int MAX_TERMS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [3:0]   cfg_terms,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    localparam int MW = W - 1;                   // magnitude width
    localparam int CW = $clog2(MAX_TERMS) + 1;   // wide enough to hold MAX_TERMS

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n_terms;
    logic          sat;

    logic          accept;
    logic          last_term;
    logic [CW-1:0] cfg_n;
    logic [W-1:0]  term_norm;
    logic [W-1:0]  sum_data;
    logic          sum_sat;

    // Term count requested for a new group; the 4-bit field uses 0 for the maximum.
    assign cfg_n  = (cfg_terms == 4'd0) ? CW'(MAX_TERMS) : CW'(cfg_terms);
    assign accept = in_valid && in_ready;

    // The term being accepted closes the group: on the first term this is the
    // N=1 case, and afterwards it is the term that brings the count up to N.
    always_comb begin
        last_term = 1'b0;
        if (state == IDLE) begin
            last_term = (cfg_n == CW'(1));
        end else if (state == ACC) begin
            last_term = ((cnt + CW'(1)) == n_terms);
        end
    end

    // Sign-magnitude add of accumulator and incoming term. A negative zero on
    // either side is treated as +0, so every zero result comes out as +0.
    always_comb begin
        logic [MW-1:0] mag_a;
        logic [MW-1:0] mag_b;
        logic          sign_a;
        logic          sign_b;
        logic [MW:0]   wide;

        mag_a    = acc[MW-1:0];
        mag_b    = in_data[MW-1:0];
        sign_a   = acc[W-1] & (|mag_a);
        sign_b   = in_data[W-1] & (|mag_b);
        wide     = {1'b0, mag_a} + {1'b0, mag_b};
        sum_data = '0;
        sum_sat  = 1'b0;

        term_norm = {sign_b, mag_b};

        if (sign_a == sign_b) begin
            if (wide[MW]) begin
                sum_data = {sign_a, {MW{1'b1}}};
                sum_sat  = 1'b1;
            end else begin
                sum_data = {sign_a & (|wide[MW-1:0]), wide[MW-1:0]};
            end
        end else if (mag_b > mag_a) begin
            sum_data = {sign_b, mag_b - mag_a};
        end else if (mag_a > mag_b) begin
            sum_data = {sign_a, mag_a - mag_b};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. clear wins over any accept or output handshake.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) next_state = last_term ? HOLD : ACC;
                ACC:  if (accept && last_term) next_state = HOLD;
                HOLD: if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, apart from in_ready, which is
    // also held low while reset is asserted.
    always_comb begin
        in_ready  = rst_n && (state != HOLD);
        out_valid = (state == HOLD);
        out_data  = out_valid ? acc : '0;
        out_sat   = out_valid && sat;
    end

    // Datapath registers. The first term of a group loads the accumulator
    // directly and starts a fresh saturation flag. Later terms go through the
    // sign-magnitude adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            n_terms <= '0;
            sat     <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            cnt     <= '0;
            n_terms <= '0;
            sat     <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc     <= term_norm;
                cnt     <= CW'(1);
                n_terms <= cfg_n;
                sat     <= 1'b0;
            end else begin
                acc     <= sum_data;
                cnt     <= cnt + CW'(1);
                sat     <= sat | sum_sat;
            end
        end
    end

endmodule
